subtr_div_ctrl: RTL and testbench

- Multi-cycle controller that sequences one shared WIDTH-bit ripple subtractor (borrow-out style, borrow-in tied 0) to perform unsigned restoring division.
- One subtraction per clock, one quotient bit per iteration.
- Sits beside the ALU as the divide unit. Start/done handshake toward the sequencer; quotient/remainder held until the next accepted start.

---
 rtl/subtr_div_ctrl_if.sv | 24 ++
 rtl/subtr_div_ctrl.sv | 127 ++++++++++++
 tb/tb_subtr_div_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/subtr_div_ctrl_if.sv
// Start/done divide handshake between the sequencer (master) and the divide unit (slave).
// Results stay registered on the slave side until the next accepted start.
interface subtr_div_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/subtr_div_ctrl.sv
// Restoring unsigned divider on one shared ripple subtractor: WIDTH iterations, done WIDTH+1 cycles after accept
// (next cycle for divide-by-zero); start is only accepted in IDLE/DONE and ignored while busy.
module subtr_div_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    subtr_div_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] v_q;
    // Partial remainder is always below V and only ever holds a WIDTH-1 bit dividend prefix.
    logic [WIDTH-2:0] r_q;
    logic [WIDTH-2:0] q_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dbz;

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    assign t = {r_q, d_q[WIDTH-1]};

    always_comb begin
        logic b;
        b    = 1'b0;
        diff = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = t[i] ^ v_q[i] ^ b;
            b       = (~t[i] & v_q[i]) | (~(t[i] ^ v_q[i]) & b);
        end
        borrow_out = b;
    end

    assign r_next = borrow_out ? t : diff;
    assign q_next = {q_q, ~borrow_out};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = (bus.divisor == '0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q <= '0;
            v_q <= '0;
            r_q <= '0;
            q_q <= '0;
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            dbz <= 1'b0;
        end else if (accept) begin
            if (bus.divisor == '0) begin
                quo <= '1;
                rem <= bus.dividend;
                dbz <= 1'b1;
            end else begin
                d_q <= bus.dividend;
                v_q <= bus.divisor;
                r_q <= '0;
                q_q <= '0;
                cnt <= '0;
                dbz <= 1'b0;
            end
        end else if (state == RUN) begin
            d_q <= {d_q[WIDTH-2:0], 1'b0};
            r_q <= r_next[WIDTH-2:0];
            q_q <= q_next[WIDTH-2:0];
            cnt <= cnt + CW'(1);
            if (last) begin
                quo <= q_next;
                rem <= r_next;
            end
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_subtr_div_ctrl.sv
// Directed and random checks of the restoring divider handshake, latency and results.
module tb_subtr_div_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks  = 0;
    int   n_fails   = 0;
    int   done_seen = 0;

    subtr_div_ctrl_if #(.WIDTH(WIDTH)) bus ();

    subtr_div_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) done_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_q"},    32'(bus.quotient), 0);
        check({tag, "_r"},    32'(bus.remainder), 0);
        check({tag, "_dbz"},  32'(bus.div_by_zero), 0);
    endtask

    // Called at a falling edge with cyc0 cycles elapsed since the accepting cycle.
    task automatic finish_op(input string tag, input int cyc0, input int b0, input int exp_lat,
                             input int exp_busy, input logic [7:0] eq, input logic [7:0] er,
                             input logic edbz);
        int cyc = cyc0;
        int bc  = b0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.busy === 1'b1) bc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
        check({tag, "_q"}, 32'(bus.quotient), 32'(eq));
        check({tag, "_r"}, 32'(bus.remainder), 32'(er));
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edbz));
    endtask

    task automatic run_single(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] eq, input logic [7:0] er, input logic edbz);
        issue(a, b);
        @(negedge clk);
        bus.start = 1'b0;
        finish_op(tag, 1, (bus.busy === 1'b1) ? 1 : 0, edbz ? 1 : 9, edbz ? 0 : 8, eq, er, edbz);
    endtask

    initial begin
        int d0;
        int cyc;
        logic [7:0] ra, rb;

        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.dividend = 8'hAA;
        bus.divisor  = 8'h03;

        // Reset with a pending start: nothing may begin.
        repeat (2) begin
            @(negedge clk);
            check_zero_outputs("reset");
        end
        rst_n     = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("post_reset_busy", 32'(bus.busy), 0);
        check("post_reset_done", 32'(bus.done), 0);

        run_single("div_200_7",   8'd200, 8'd7,   8'd28,  8'd4, 1'b0);
        run_single("div_255_1",   8'd255, 8'd1,   8'd255, 8'd0, 1'b0);
        run_single("div_5_9",     8'd5,   8'd9,   8'd0,   8'd5, 1'b0);
        run_single("div_255_255", 8'd255, 8'd255, 8'd1,   8'd0, 1'b0);

        run_single("div_by_zero", 8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b1);
        run_single("div_10_3",    8'd10, 8'd3,  8'd3,  8'd1,  1'b0);

        // Start pulsed during RUN cycle 3 must be ignored.
        issue(8'd100, 8'd10);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        issue(8'd7, 8'd2);
        @(negedge clk);
        bus.start = 1'b0;
        finish_op("start_in_run", 4, 4, 9, 8, 8'd10, 8'd0, 1'b0);

        // Start on the DONE cycle: back-to-back with no idle bubble.
        issue(8'd7, 8'd2);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy_first", 32'(bus.busy), 1);
        finish_op("b2b_7_2", 1, 1, 9, 8, 8'd3, 8'd1, 1'b0);

        // Reset in RUN cycle 4 aborts without a done pulse.
        @(negedge clk);
        issue(8'd200, 8'd7);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        d0    = done_seen;
        rst_n = 1'b0;
        @(negedge clk);
        check_zero_outputs("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_reset_idle_busy", 32'(bus.busy), 0);
        check("mid_reset_idle_done", 32'(bus.done), 0);
        check("mid_reset_no_done", 32'(done_seen), 32'(d0));
        run_single("after_reset_200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);

        // Random back-to-back stream with start held high.
        @(negedge clk);
        d0 = done_seen;
        ra = 8'($urandom_range(255, 0));
        rb = 8'($urandom_range(255, 1));
        issue(ra, rb);
        for (int i = 0; i < 1000; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (bus.done !== 1'b1 && cyc < 20);
            check("rand_latency", 32'(cyc), 9);
            check("rand_q", 32'(bus.quotient), 32'(ra / rb));
            check("rand_r", 32'(bus.remainder), 32'(ra % rb));
            if (i < 999) begin
                ra = 8'($urandom_range(255, 0));
                rb = 8'($urandom_range(255, 1));
                issue(ra, rb);
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        check("rand_done_count", 32'(done_seen - d0), 1000);
        check("rand_final_done", 32'(bus.done), 0);
        check("rand_final_busy", 32'(bus.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
